// File: rtl/thread_req_responder.sv
// thread_req_responder
//
// Dispatcher-side responder for the inter-CPU thread-control message protocol.
// It watches the shared cpu_msg bus for FORK/STOP thread requests and latches
// the accompanying addr/data words. Each request is queued in a small
// first-word-fall-through FIFO for the thread scheduler. Once the request is
// queued, the block answers on the bus with the matching DONE code for
// ACK_HOLD edges.
//
// All state advances on the falling edge of clk, which matches the thread
// controllers. rst is asynchronous and active-high.
//
// Optional feature macro: THREAD_REQ_STATS_EN
//   Adds fork_cnt/stop_cnt (16-bit saturating push counters) and a sticky
//   drop_err flag. drop_err is set when a request code appears while a
//   request is already outstanding.
//
// Ports:
//   clk, rst        clock (negedge active), async active-high reset
//   disp_online     dispatcher present; requests are recognised only while 1
//   msg_in          sampled cpu_msg bus
//   msg_out/msg_oe  value and drive enable toward cpu_msg (msg_out 0 when idle)
//   addr, data      request payload words
//   req_valid       FIFO not empty
//   req_kind        head kind (0 fork, 1 stop)
//   req_addr        head address
//   req_data        head data
//   req_ready       consumer pop
//   fifo_level      occupied entries, 0..DEPTH
//   busy            FSM not idle
//   fork_cnt, stop_cnt, drop_err   (THREAD_REQ_STATS_EN only)

module thread_req_responder #(
    parameter int         DEPTH           = 4,
    parameter int         ACK_HOLD        = 2,
    parameter int         ADDR_SIZE       = 32,
    parameter int         DATA_SIZE       = 32,
    parameter logic [7:0] CPU_R_FORK_THRD = 8'h10,
    parameter logic [7:0] CPU_R_FORK_DONE = 8'h11,
    parameter logic [7:0] CPU_R_STOP_THRD = 8'h12,
    parameter logic [7:0] CPU_R_STOP_DONE = 8'h13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     disp_online,
    input  logic [7:0]               msg_in,
    output logic [7:0]               msg_out,
    output logic                     msg_oe,
    input  logic [ADDR_SIZE-1:0]     addr,
    input  logic [DATA_SIZE-1:0]     data,
    output logic                     req_valid,
    output logic                     req_kind,
    output logic [ADDR_SIZE-1:0]     req_addr,
    output logic [DATA_SIZE-1:0]     req_data,
    input  logic                     req_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy
`ifdef THREAD_REQ_STATS_EN
    ,
    output logic [15:0]              fork_cnt,
    output logic [15:0]              stop_cnt,
    output logic                     drop_err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(ACK_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic                 pend_kind;
    logic [ADDR_SIZE-1:0] pend_addr;
    logic [DATA_SIZE-1:0] pend_data;

    logic                 mem_kind [DEPTH];
    logic [ADDR_SIZE-1:0] mem_addr [DEPTH];
    logic [DATA_SIZE-1:0] mem_data [DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level_q;

    logic is_fork, is_stop, req_code, is_req;
    logic empty, full, pop, push;

    // Equality against X/Z evaluates unknown, which the if-statements below
    // treat as false, so undriven or floating bus values are never captured.
    assign is_fork  = (msg_in == CPU_R_FORK_THRD);
    assign is_stop  = (msg_in == CPU_R_STOP_THRD);
    assign req_code = is_fork || is_stop;
    assign is_req   = disp_online && req_code;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign pop   = !empty && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_req) state_d = HOLD;
            end
            HOLD: begin
                if (!disp_online) begin
                    state_d = IDLE;
                end else if (!full || pop) begin
                    push    = 1'b1;
                    state_d = ACK;
                    cnt_d   = CW'(ACK_HOLD);
                end
            end
            ACK: begin
                if (!disp_online) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_kind <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && is_req) begin
                pend_kind <= is_stop;
                pend_addr <= addr;
                pend_data <= data;
            end
        end
    end

    always_ff @(negedge clk) begin
        if (push) begin
            mem_kind[wr_ptr] <= pend_kind;
            mem_addr[wr_ptr] <= pend_addr;
            mem_data[wr_ptr] <= pend_data;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // The enable is gated by disp_online so the bus is released the moment the
    // dispatcher goes away, without waiting for the next falling edge.
    assign msg_oe  = (state_q == ACK) && disp_online;
    assign msg_out = msg_oe ? (pend_kind ? CPU_R_STOP_DONE : CPU_R_FORK_DONE) : 8'h00;
    assign busy    = (state_q != IDLE);

    // Head is forced to zero when empty so the outputs read as reset values
    // rather than stale memory contents.
    assign req_valid  = !empty;
    assign req_kind   = req_valid ? mem_kind[rd_ptr] : 1'b0;
    assign req_addr   = req_valid ? mem_addr[rd_ptr] : '0;
    assign req_data   = req_valid ? mem_data[rd_ptr] : '0;
    assign fifo_level = level_q;

`ifdef THREAD_REQ_STATS_EN
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            fork_cnt <= '0;
            stop_cnt <= '0;
            drop_err <= 1'b0;
        end else begin
            if (push && !pend_kind && fork_cnt != 16'hFFFF) fork_cnt <= fork_cnt + 1'b1;
            if (push &&  pend_kind && stop_cnt != 16'hFFFF) stop_cnt <= stop_cnt + 1'b1;
            if (disp_online && req_code && state_q != IDLE) drop_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_thread_req_responder.sv
module tb_thread_req_responder;

    localparam logic [7:0] FORK_T = 8'h10;
    localparam logic [7:0] FORK_D = 8'h11;
    localparam logic [7:0] STOP_T = 8'h12;
    localparam logic [7:0] STOP_D = 8'h13;

    logic        clk;
    logic        rst;
    logic        disp_online;
    logic [7:0]  msg_in;
    logic [7:0]  msg_out;
    logic        msg_oe;
    logic [31:0] addr;
    logic [31:0] data;
    logic        req_valid;
    logic        req_kind;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_ready;
    logic [2:0]  fifo_level;
    logic        busy;
`ifdef THREAD_REQ_STATS_EN
    logic [15:0] fork_cnt;
    logic [15:0] stop_cnt;
    logic        drop_err;
`endif

    int vectors;
    int miscompares;

    // {busy, msg_oe, msg_out, req_valid, req_kind, fifo_level}
    logic [14:0] st;
    assign st = {busy, msg_oe, msg_out, req_valid, req_kind, fifo_level};

    thread_req_responder dut (
        .clk         (clk),
        .rst         (rst),
        .disp_online (disp_online),
        .msg_in      (msg_in),
        .msg_out     (msg_out),
        .msg_oe      (msg_oe),
        .addr        (addr),
        .data        (data),
        .req_valid   (req_valid),
        .req_kind    (req_kind),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_level  (fifo_level),
        .busy        (busy)
`ifdef THREAD_REQ_STATS_EN
        ,
        .fork_cnt    (fork_cnt),
        .stop_cnt    (stop_cnt),
        .drop_err    (drop_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are checked just after a rising edge; the DUT
    // acts on the falling edge in between.
    task automatic next_edge();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic test_reset();
        logic [14:0] exp;
        rst = 1'b1; disp_online = 1'b1; msg_in = 8'h00;
        addr = '0; data = '0; req_ready = 1'b0;
        @(posedge clk);
        exp = {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
        vectors++;
        if (st !== exp) begin
            miscompares++;
            $display("FAIL reset_status got %h exp %h", st, exp);
        end
        vectors++;
        if ({req_addr, req_data} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_head got %h_%h exp 0_0", req_addr, req_data);
        end
        rst = 1'b0;
        next_edge();
    endtask

    task automatic test_fork();
        logic [14:0] exp;
        msg_in = FORK_T; addr = 32'h100; data = 32'h2000; req_ready = 1'b0;
        next_edge();
        msg_in = 8'h00; addr = 32'hDEAD; data = 32'hBEEF;
        exp = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
        vectors++;
        if (st !== exp) begin
            miscompares++;
            $display("FAIL fork_hold got %h exp %h", st, exp);
        end
        next_edge();
        exp = {1'b1, 1'b1, FORK_D, 1'b1, 1'b0, 3'd1};
        vectors++;
        if (st !== exp) begin
            miscompares++;
            $display("FAIL fork_ack1 got %h exp %h", st, exp);
        end
        vectors++;
        if ({req_addr, req_data} !== {32'h100, 32'h2000}) begin
            miscompares++;
            $display("FAIL fork_head got %h_%h exp 100_2000", req_addr, req_data);
        end
        next_edge();
        exp = {1'b1, 1'b1, FORK_D, 1'b1, 1'b0, 3'd1};
        vectors++;
        if (st !== exp) begin
            miscompares++;
            $display("FAIL fork_ack2 got %h exp %h", st, exp);
        end
        next_edge();
        exp = {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd1};
        vectors++;
        if (st !== exp) begin
            miscompares++;
            $display("FAIL fork_release got %h exp %h", st, exp);
        end
    endtask

    task automatic test_stop();
        logic [14:0] exp;
        msg_in = STOP_T; addr = 32'h200; data = 32'h0;
        next_edge();
        msg_in = 8'h00;
        next_edge();
        exp = {1'b1, 1'b1, STOP_D, 1'b1, 1'b0, 3'd2};
        vectors++;
        if (st !== exp) begin
            miscompares++;
            $display("FAIL stop_ack got %h exp %h", st, exp);
        end
        next_edge();
        next_edge();
        req_ready = 1'b1;
        next_edge();
        req_ready = 1'b0;
        exp = {1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd1};
        vectors++;
        if (st !== exp) begin
            miscompares++;
            $display("FAIL stop_head_status got %h exp %h", st, exp);
        end
        vectors++;
        if ({req_addr, req_data} !== {32'h200, 32'h0}) begin
            miscompares++;
            $display("FAIL stop_head got %h_%h exp 200_0", req_addr, req_data);
        end
    endtask

    task automatic test_full();
        logic [14:0] exp;
        // Entry 0x200 (stop) is already queued; add forks 0x300..0x500.
        for (int i = 0; i < 3; i++) begin
            msg_in = FORK_T; addr = 32'h300 + 32'(i) * 32'h100; data = 32'h3000 + 32'(i);
            next_edge();
            msg_in = 8'h00;
            for (int k = 0; k < 3; k++) next_edge();
        end
        vectors++;
        if (fifo_level !== 3'd4) begin
            miscompares++;
            $display("FAIL full_level got %0d exp 4", fifo_level);
        end
        msg_in = FORK_T; addr = 32'h600; data = 32'h3003;
        next_edge();
        msg_in = 8'h00;
        next_edge();
        next_edge();
        exp = {1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd4};
        vectors++;
        if (st !== exp) begin
            miscompares++;
            $display("FAIL full_backpressure got %h exp %h", st, exp);
        end
        req_ready = 1'b1;
        next_edge();
        req_ready = 1'b0;
        exp = {1'b1, 1'b1, FORK_D, 1'b1, 1'b0, 3'd4};
        vectors++;
        if (st !== exp) begin
            miscompares++;
            $display("FAIL full_push_pop got %h exp %h", st, exp);
        end
        next_edge();
        next_edge();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({req_valid, req_kind, req_addr, req_data} !==
                {1'b1, 1'b0, 32'h300 + 32'(i) * 32'h100, 32'h3000 + 32'(i)}) begin
                miscompares++;
                $display("FAIL drain_%0d got v%b k%b %h_%h exp addr %h", i,
                         req_valid, req_kind, req_addr, req_data, 32'h300 + 32'(i) * 32'h100);
            end
            req_ready = 1'b1;
            next_edge();
        end
        req_ready = 1'b1;
        next_edge();
        req_ready = 1'b0;
        exp = {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
        vectors++;
        if (st !== exp || req_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL drain_empty got %h addr %h exp %h addr 0", st, req_addr, exp);
        end
    endtask

    task automatic test_offline();
        logic [14:0] exp;
        disp_online = 1'b0; msg_in = FORK_T; addr = 32'h999;
        next_edge();
        next_edge();
        exp = {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
        vectors++;
        if (st !== exp) begin
            miscompares++;
            $display("FAIL offline_ignore got %h exp %h", st, exp);
        end
        disp_online = 1'b1; msg_in = 8'h42;
        next_edge();
        msg_in = 8'hxx;
        next_edge();
        msg_in = FORK_D;
        next_edge();
        msg_in = 8'h00;
        vectors++;
        if (st !== exp) begin
            miscompares++;
            $display("FAIL other_codes_ignored got %h exp %h", st, exp);
        end
    endtask

    task automatic test_drop_in_hold();
        logic [14:0] exp;
        msg_in = FORK_T; addr = 32'h777; data = 32'h1;
        next_edge();
        msg_in = 8'h00; disp_online = 1'b0;
        next_edge();
        exp = {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
        vectors++;
        if (st !== exp) begin
            miscompares++;
            $display("FAIL hold_offline got %h exp %h", st, exp);
        end
        disp_online = 1'b1;
        next_edge();
        next_edge();
        vectors++;
        if (st !== exp) begin
            miscompares++;
            $display("FAIL hold_offline_no_done got %h exp %h", st, exp);
        end
    endtask

    task automatic test_drop_in_ack();
        logic [14:0] exp;
        msg_in = STOP_T; addr = 32'h880; data = 32'h2;
        next_edge();
        msg_in = 8'h00;
        next_edge();
        disp_online = 1'b0;
        #1;
        exp = {1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd1};
        vectors++;
        if (st !== exp) begin
            miscompares++;
            $display("FAIL ack_offline_immediate got %h exp %h", st, exp);
        end
        next_edge();
        disp_online = 1'b1;
        exp = {1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd1};
        vectors++;
        if (st !== exp) begin
            miscompares++;
            $display("FAIL ack_offline_idle got %h exp %h", st, exp);
        end
        req_ready = 1'b1;
        next_edge();
        req_ready = 1'b0;
    endtask

    task automatic test_ignore_in_ack();
        logic [14:0] exp;
        msg_in = FORK_T; addr = 32'hA00; data = 32'hA;
        next_edge();
        msg_in = 8'h00;
        next_edge();
        msg_in = STOP_T; addr = 32'hB00;
        next_edge();
        msg_in = 8'h00;
        next_edge();
        next_edge();
        exp = {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd1};
        vectors++;
        if (st !== exp || req_addr !== 32'hA00) begin
            miscompares++;
            $display("FAIL ignore_in_ack got %h addr %h exp %h addr a00", st, req_addr, exp);
        end
`ifdef THREAD_REQ_STATS_EN
        vectors++;
        if (drop_err !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_err got %b exp 1", drop_err);
        end
`endif
        req_ready = 1'b1;
        next_edge();
        req_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp;
        msg_in = FORK_T; addr = 32'hC00; data = 32'hC;
        next_edge();
        msg_in = 8'h00;
        next_edge();
        next_edge();
        next_edge();
        msg_in = STOP_T; addr = 32'hD00; data = 32'hD;
        next_edge();
        msg_in = 8'h00;
        exp = {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd1};
        vectors++;
        if (st !== exp) begin
            miscompares++;
            $display("FAIL b2b_second_hold got %h exp %h", st, exp);
        end
        next_edge();
        next_edge();
        next_edge();
        exp = {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd2};
        vectors++;
        if (st !== exp) begin
            miscompares++;
            $display("FAIL b2b_level got %h exp %h", st, exp);
        end
        req_ready = 1'b1;
        next_edge();
        req_ready = 1'b0;
        vectors++;
        if ({req_kind, req_addr, req_data} !== {1'b1, 32'hD00, 32'hD}) begin
            miscompares++;
            $display("FAIL b2b_second_head got k%b %h_%h exp k1 d00_d", req_kind, req_addr, req_data);
        end
    endtask

    task automatic test_reset_mid_ack();
        logic [14:0] exp;
        msg_in = FORK_T; addr = 32'hE00; data = 32'hE;
        next_edge();
        msg_in = 8'h00;
        next_edge();
        #2 rst = 1'b1;
        #1;
        exp = {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
        vectors++;
        if (st !== exp || req_addr !== 32'h0 || req_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_ack got %h addr %h data %h exp %h", st, req_addr, req_data, exp);
        end
`ifdef THREAD_REQ_STATS_EN
        vectors++;
        if ({fork_cnt, stop_cnt, drop_err} !== 33'h0) begin
            miscompares++;
            $display("FAIL reset_stats got %h %h %b exp 0", fork_cnt, stop_cnt, drop_err);
        end
`endif
        #1 rst = 1'b0;
        @(posedge clk);
        next_edge();
        next_edge();
        vectors++;
        if (st !== exp) begin
            miscompares++;
            $display("FAIL reset_no_done got %h exp %h", st, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_fork();
        test_stop();
        test_full();
        test_offline();
        test_drop_in_hold();
        test_drop_in_ack();
        test_ignore_in_ack();
        test_back_to_back();
        test_reset_mid_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/thread_req_responder.md
# thread_req_responder

Dispatcher-side responder for the inter-CPU thread-control message protocol. It watches the shared `cpu_msg` bus for `CPU_R_FORK_THRD` and `CPU_R_STOP_THRD` requests from a CPU thread controller and captures the accompanying `addr`/`data` words. Each captured request is queued in a small FIFO for the dispatcher's thread scheduler. Once the request is queued, the block answers on the bus with `CPU_R_FORK_DONE` or `CPU_R_STOP_DONE`.

## Interface
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `ACK_HOLD`, 2: edges the DONE code is driven; ≥1.
- `clk`  in  1  clock; all state updates on negedge, matching the thread controllers.
- `rst`  in  1  reset, asynchronous, active-high.
- `disp_online`  in  1  dispatcher present; requests are recognised only while 1.
- `msg_in`  in  8  sampled value of the `cpu_msg` bus.
- `msg_out`  out  8  value to drive onto `cpu_msg`.
- `msg_oe`  out  1  drive enable for `msg_out`; bus is high-Z when 0.
- `addr`  in  `ADDR_SIZE`  request address (thread entry).
- `data`  in  `DATA_SIZE`  request data (thread data base, 0 = none).
- `req_valid`  out  1  FIFO not empty.
- `req_kind`  out  1  head kind: 0 = fork, 1 = stop.
- `req_addr`  out  `ADDR_SIZE`  head address.
- `req_data`  out  `DATA_SIZE`  head data.
- `req_ready`  in  1  consumer pop.
- `fifo_level`  out  clog2(DEPTH)+1  occupied entries.
- `busy`  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, HOLD, ACK.
- IDLE → HOLD:
  - Condition: `disp_online`=1 and `msg_in` === `CPU_R_FORK_THRD` or `CPU_R_STOP_THRD`.
  - Action: latch `addr`, `data` and kind into a pending register on the same edge.
  - Any other code, X, or Z is ignored.
- HOLD:
  - Push the pending entry when the FIFO is not full, or is full and a pop occurs on the same edge; then → ACK and load the hold counter with `ACK_HOLD`.
  - Otherwise stay in HOLD (back-pressure; the initiator keeps waiting).
- ACK:
  - `msg_oe`=1; `msg_out` = `CPU_R_FORK_DONE` or `CPU_R_STOP_DONE` per kind.
  - The counter decrements each edge; on reaching 0 → IDLE.
- Requests seen on the bus while in HOLD or ACK are ignored: one outstanding request at a time.
- `disp_online` falls:
  - in HOLD: the pending entry is discarded, → IDLE, no DONE.
  - in ACK: `msg_oe` is dropped immediately and → IDLE.
  - Entries already in the FIFO are retained.
- FIFO:
  - First-word fall-through; `req_*` show the head whenever `req_valid`=1.
  - Pop on an edge with `req_valid`&&`req_ready`; `req_ready` is ignored when empty.
  - Pointers wrap modulo `DEPTH`. `fifo_level` is exact, 0..`DEPTH`.
- Captured values are stored unmodified; no address arithmetic in this block.

## Timing
- Reset (async) values:
  - FSM IDLE; pending register, pointers and `fifo_level` 0.
  - `msg_oe`=0, `msg_out`=8'h00, `req_valid`=0, `req_kind`=0, `req_addr`=0, `req_data`=0, `busy`=0.
  - Reset mid-request loses the pending entry; no DONE is issued.
- Request sampled at edge N.
- Push at edge N+1 if space; `req_valid` visible after N+1.
- DONE driven for edges N+1 .. N+`ACK_HOLD` (outputs registered, valid after N+1).
- `msg_oe`=0 again after edge N+`ACK_HOLD`+1.
- Minimum request-to-request spacing: `ACK_HOLD`+2 edges.
- `msg_out` is 8'h00 whenever `msg_oe`=0.
- Simultaneous push and pop: level unchanged. When empty, the pushed entry is not popped on the same edge.

## Configuration
- `THREAD_REQ_STATS_EN` defined:
  - Adds outputs `fork_cnt` and `stop_cnt` (each 16 bits), cleared by `rst`.
  - Each increments on a push of its kind and saturates at 16'hFFFF.
  - Adds sticky `drop_err` (1 bit), set when a request code is seen outside IDLE while `disp_online`=1.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

## Test plan
- Fork, empty FIFO:
  - Stimulus: `msg_in`=`CPU_R_FORK_THRD`, `addr`=0x100, `data`=0x2000 at edge N, `req_ready`=0.
  - Response: `req_valid`=1, kind 0, 0x100/0x2000 after N+1; `CPU_R_FORK_DONE` with `msg_oe`=1 for exactly 2 edges; `fifo_level`=1.
- Stop, `data`=0:
  - Response: kind 1, `req_data`=0, `CPU_R_STOP_DONE` driven.
- FIFO full (4 entries), 5th fork:
  - Response: stays in HOLD and `busy`=1 with no DONE; after one `req_ready` pop, push and DONE on the next edge; level stays 4.
- `disp_online`=0 with a fork code on the bus:
  - Response: no capture, `msg_oe`=0.
- `disp_online` dropped while in HOLD:
  - Response: → IDLE, level unchanged.
- Async `rst` pulse mid-ACK:
  - Response: `msg_oe`=0 immediately and all outputs at reset values.
  - With `THREAD_REQ_STATS_EN`: counters 0; a 2nd fork during ACK sets `drop_err` and `fork_cnt` increments only once.
